// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: FSM state type, default
// parameter values and a small counter-width helper.
package operand_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/operand_sequencer_edge_detect.sv
// Rising-edge detector for the digit strobe.
// Ports:
//   i_clk   - rising-edge clock
//   i_rst   - asynchronous active-high reset
//   i_level - raw strobe level (DigitValid)
//   o_pulse - high for the single cycle where i_level is 1 and was 0 before
module operand_sequencer_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_d;

  // Remember the previous strobe level; tracks in every FSM state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_level_d;

endmodule

// File: rtl/operand_sequencer.sv
// Collects two hex operands digit by digit, presents them to an external
// ripple-carry adder, waits for the chain to settle and latches the sum.
// Ports:
//   Clk, Rst          - clock, asynchronous active-high reset
//   DigitIn/DigitValid - hex digit and its strobe (a held level is one entry)
//   Clear             - synchronous abort back to operand-A entry
//   SumIn/CarryIn     - results returned by the adder chain
//   OpA/OpB/CinOut    - operands and carry-in driven to the adder chain
//   Result/ResultValid - latched {carry, sum} and its valid flag
//   Busy              - high while waiting for the adder to settle
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       DigitIn,
  input  logic             DigitValid,
  input  logic             Clear,
  input  logic [WIDTH-1:0] SumIn,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] OpA,
  output logic [WIDTH-1:0] OpB,
  output logic             CinOut,
  output logic [WIDTH:0]   Result,
  output logic             ResultValid,
  output logic             Busy
);

  localparam int DIGITS = WIDTH / 4;
  localparam int DCW    = cnt_width(DIGITS);
  localparam int SCW    = cnt_width(SETTLE_CYCLES);

  localparam logic [DCW-1:0] LAST_DIGIT  = DCW'(DIGITS - 1);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] w_op_a_nxt;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] w_op_b_nxt;
  logic [WIDTH:0]   r_result;
  logic [WIDTH:0]   w_result_nxt;
  logic             r_result_valid;
  logic             w_result_valid_nxt;
  logic             r_busy;
  logic [DCW-1:0]   r_digit_cnt;
  logic [DCW-1:0]   w_digit_cnt_nxt;
  logic [SCW-1:0]   r_settle_cnt;
  logic [SCW-1:0]   w_settle_cnt_nxt;
  // Set once the settle counter has been observed at zero; the sum is
  // captured on the cycle after that, giving SETTLE_CYCLES+1 of latency.
  logic             r_settle_zero;
  logic             w_settle_zero_nxt;

  logic             w_accept;
  logic [WIDTH-1:0] w_shift_a;
  logic [WIDTH-1:0] w_shift_b;

  operand_sequencer_edge_detect u_edge_detect (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_level (DigitValid),
    .o_pulse (w_accept)
  );

  // Truncating cast drops the top nibble, which also works when WIDTH is 4.
  assign w_shift_a = WIDTH'({r_op_a, DigitIn});
  assign w_shift_b = WIDTH'({r_op_b, DigitIn});

  // Next-state and datapath decisions; Clear overrides everything.
  always_comb begin
    w_state_nxt        = r_state;
    w_op_a_nxt         = r_op_a;
    w_op_b_nxt         = r_op_b;
    w_result_nxt       = r_result;
    w_result_valid_nxt = r_result_valid;
    w_digit_cnt_nxt    = r_digit_cnt;
    w_settle_cnt_nxt   = r_settle_cnt;
    w_settle_zero_nxt  = r_settle_zero;

    if (Clear) begin
      w_state_nxt        = ST_ENTER_A;
      w_op_a_nxt         = '0;
      w_op_b_nxt         = '0;
      w_result_nxt       = '0;
      w_result_valid_nxt = 1'b0;
      w_digit_cnt_nxt    = '0;
      w_settle_cnt_nxt   = '0;
      w_settle_zero_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_ENTER_A: begin
          if (w_accept) begin
            w_op_a_nxt = w_shift_a;
            if (r_digit_cnt == LAST_DIGIT) begin
              w_digit_cnt_nxt = '0;
              w_state_nxt     = ST_ENTER_B;
            end else begin
              w_digit_cnt_nxt = r_digit_cnt + DCW'(1);
            end
          end else begin
            w_op_a_nxt = r_op_a;
          end
        end
        ST_ENTER_B: begin
          if (w_accept) begin
            w_op_b_nxt = w_shift_b;
            if (r_digit_cnt == LAST_DIGIT) begin
              w_digit_cnt_nxt   = '0;
              w_settle_cnt_nxt  = SETTLE_LOAD;
              w_settle_zero_nxt = 1'b0;
              w_state_nxt       = ST_COMPUTE;
            end else begin
              w_digit_cnt_nxt = r_digit_cnt + DCW'(1);
            end
          end else begin
            w_op_b_nxt = r_op_b;
          end
        end
        ST_COMPUTE: begin
          // Strobe edges are ignored here; the edge detector still tracks.
          if (r_settle_cnt != '0) begin
            w_settle_cnt_nxt = r_settle_cnt - SCW'(1);
          end else if (!r_settle_zero) begin
            w_settle_zero_nxt = 1'b1;
          end else begin
            w_result_nxt       = {CarryIn, SumIn};
            w_result_valid_nxt = 1'b1;
            w_settle_zero_nxt  = 1'b0;
            w_state_nxt        = ST_DONE;
          end
        end
        ST_DONE: begin
          // A new digit starts the next operand A; Result keeps its value.
          if (w_accept) begin
            w_result_valid_nxt = 1'b0;
            w_op_b_nxt         = '0;
            w_op_a_nxt         = WIDTH'(DigitIn);
            if (DIGITS == 1) begin
              w_digit_cnt_nxt = '0;
              w_state_nxt     = ST_ENTER_B;
            end else begin
              w_digit_cnt_nxt = DCW'(1);
              w_state_nxt     = ST_ENTER_A;
            end
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
        default: begin
          w_state_nxt = ST_ENTER_A;
        end
      endcase
    end
  end

  // State, operand, counter and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state        <= ST_ENTER_A;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_digit_cnt    <= '0;
      r_settle_cnt   <= '0;
      r_settle_zero  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_op_a         <= w_op_a_nxt;
      r_op_b         <= w_op_b_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_busy         <= (w_state_nxt == ST_COMPUTE);
      r_digit_cnt    <= w_digit_cnt_nxt;
      r_settle_cnt   <= w_settle_cnt_nxt;
      r_settle_zero  <= w_settle_zero_nxt;
    end
  end

  assign OpA         = r_op_a;
  assign OpB         = r_op_b;
  assign CinOut      = 1'b0;
  assign Result      = r_result;
  assign ResultValid = r_result_valid;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: directed scenarios plus random
// operand pairs, checked against a digit-level reference model. The bench
// also plays the role of the adder chain.
module tb_operand_sequencer;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
  localparam int DIGITS = WIDTH / 4;
  localparam int MASK   = (1 << WIDTH) - 1;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [3:0]       DigitIn = 4'h0;
  logic             DigitValid = 1'b0;
  logic             Clear = 1'b0;
  logic [WIDTH-1:0] SumIn;
  logic             CarryIn;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             CinOut;
  logic [WIDTH:0]   Result;
  logic             ResultValid;
  logic             Busy;
  logic [WIDTH:0]   w_add;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_phase = 0;  // 0: entering A, 1: entering B, 2: computing or done
  int m_cnt = 0;
  int m_a = 0;
  int m_b = 0;
  int m_result = 0;
  int m_valid = 0;

  operand_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .DigitIn     (DigitIn),
    .DigitValid  (DigitValid),
    .Clear       (Clear),
    .SumIn       (SumIn),
    .CarryIn     (CarryIn),
    .OpA         (OpA),
    .OpB         (OpB),
    .CinOut      (CinOut),
    .Result      (Result),
    .ResultValid (ResultValid),
    .Busy        (Busy)
  );

  // adder chain stand-in
  assign w_add   = {1'b0, OpA} + {1'b0, OpB} + {{WIDTH{1'b0}}, CinOut};
  assign SumIn   = w_add[WIDTH-1:0];
  assign CarryIn = w_add[WIDTH];

  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_a = 0; m_b = 0; m_result = 0; m_valid = 0;
  endtask

  task automatic model_digit(input int d);
    if (m_phase == 0) begin
      m_a = ((m_a << 4) | d) & MASK;
      m_cnt++;
      if (m_cnt == DIGITS) begin m_cnt = 0; m_phase = 1; end
    end else if (m_phase == 1) begin
      m_b = ((m_b << 4) | d) & MASK;
      m_cnt++;
      if (m_cnt == DIGITS) begin
        m_cnt = 0; m_phase = 2;
        m_result = m_a + m_b;
        m_valid = 1;
      end
    end else begin
      m_a = d; m_b = 0; m_valid = 0;
      if (DIGITS == 1) begin m_cnt = 0; m_phase = 1; end
      else begin m_cnt = 1; m_phase = 0; end
    end
  endtask

  // one clean strobe pulse; returns at the falling edge after the accept edge
  task automatic press(input int d);
    @(negedge Clk);
    DigitIn = 4'(d);
    DigitValid = 1'b1;
    @(negedge Clk);
    DigitValid = 1'b0;
    model_digit(d);
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    model_reset();
  endtask

  // called right after the last operand digit: ResultValid must rise
  // exactly SETTLE+1 cycles after the accept edge, Busy covers the wait
  task automatic check_compute(input string tag, input bit poke);
    check_value({tag, "_busy_start"}, int'(Busy), 1);
    check_value({tag, "_rv_start"}, int'(ResultValid), 0);
    if (poke) begin
      DigitIn = 4'hE;
      DigitValid = 1'b1;
    end
    for (int j = 1; j <= SETTLE; j++) begin
      @(negedge Clk);
      DigitValid = 1'b0;
      check_value({tag, "_busy_wait"}, int'(Busy), 1);
      check_value({tag, "_rv_wait"}, int'(ResultValid), 0);
    end
    @(negedge Clk);
    check_value({tag, "_busy_end"}, int'(Busy), 0);
    check_value({tag, "_rv_end"}, int'(ResultValid), m_valid);
    check_value({tag, "_result"}, int'(Result), m_result);
    check_value({tag, "_opa"}, int'(OpA), m_a);
    check_value({tag, "_opb"}, int'(OpB), m_b);
  endtask

  task automatic enter_pair(input string tag, input int a, input int b, input bit poke);
    for (int i = DIGITS - 1; i >= 0; i--) press((a >> (4 * i)) & 15);
    for (int i = DIGITS - 1; i >= 1; i--) press((b >> (4 * i)) & 15);
    press(b & 15);
    check_compute(tag, poke);
  endtask

  initial begin
    // reset state
    #1;
    check_value("rst_opa", int'(OpA), 0);
    check_value("rst_opb", int'(OpB), 0);
    check_value("rst_result", int'(Result), 0);
    check_value("rst_rv", int'(ResultValid), 0);
    check_value("rst_busy", int'(Busy), 0);
    check_value("rst_cin", int'(CinOut), 0);
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();

    // 3A + 45
    enter_pair("d3a45", 'h3A, 'h45, 1'b0);
    check_value("d3a45_exp", int'(Result), 'h07F);

    // FF + 01 carries out
    enter_pair("dff01", 'hFF, 'h01, 1'b0);
    check_value("dff01_exp", int'(Result), 'h100);

    // a held strobe counts once
    @(negedge Clk);
    DigitIn = 4'h7;
    DigitValid = 1'b1;
    repeat (10) @(negedge Clk);
    DigitValid = 1'b0;
    model_digit(7);
    @(negedge Clk);
    check_value("hold_opa", int'(OpA), m_a);
    check_value("hold_opa_exp", int'(OpA), 'h07);
    check_value("hold_opb", int'(OpB), 0);
    check_value("hold_rv", int'(ResultValid), 0);
    check_value("hold_result", int'(Result), m_result);

    // clear mid-entry, then 01+01
    pulse_clear();
    press(1); press(2); press(3);
    check_value("pre_clr_opa", int'(OpA), 'h12);
    check_value("pre_clr_opb", int'(OpB), 'h03);
    pulse_clear();
    check_value("clr_opa", int'(OpA), 0);
    check_value("clr_opb", int'(OpB), 0);
    check_value("clr_result", int'(Result), 0);
    enter_pair("d0101", 'h01, 'h01, 1'b0);
    check_value("d0101_exp", int'(Result), 'h002);

    // clear and a digit edge together: digit discarded
    @(negedge Clk);
    Clear = 1'b1;
    DigitIn = 4'h5;
    DigitValid = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    DigitValid = 1'b0;
    model_reset();
    check_value("clr_dig_opa", int'(OpA), 0);
    check_value("clr_dig_rv", int'(ResultValid), 0);
    press(5);
    check_value("after_clr_dig_opa", int'(OpA), 'h05);
    pulse_clear();

    // digit edge during compute ignored; then digit 9 from DONE
    enter_pair("poke", 'h12, 'h34, 1'b1);
    check_value("poke_exp", int'(Result), 'h046);
    press(9);
    check_value("done9_opa", int'(OpA), 'h09);
    check_value("done9_opb", int'(OpB), 0);
    check_value("done9_rv", int'(ResultValid), 0);
    press(1);
    check_value("done9_cnt_opa", int'(OpA), 'h91);
    press(0);
    press(2);
    check_compute("d9102", 1'b0);
    check_value("d9102_exp", int'(Result), 'h093);

    // reset during compute
    press(4); press(5); press(6); press(7);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check_value("rstc_opa", int'(OpA), 0);
    check_value("rstc_opb", int'(OpB), 0);
    check_value("rstc_result", int'(Result), 0);
    check_value("rstc_rv", int'(ResultValid), 0);
    check_value("rstc_busy", int'(Busy), 0);
    check_value("rstc_cin", int'(CinOut), 0);
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check_value("rstc_no_rv", int'(ResultValid), 0);
      check_value("rstc_no_busy", int'(Busy), 0);
    end

    // random operand pairs, occasional aborts
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        press(int'($urandom_range(0, 15)));
        pulse_clear();
        check_value("rnd_clr_opa", int'(OpA), 0);
        check_value("rnd_clr_rv", int'(ResultValid), 0);
      end
      for (int i = 0; i < 2 * DIGITS - 1; i++) begin
        press(int'($urandom_range(0, 15)));
        check_value("rnd_entry_opa", int'(OpA), m_a);
        check_value("rnd_entry_opb", int'(OpB), m_b);
      end
      press(int'($urandom_range(0, 15)));
      check_compute("rnd", $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
